// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA exponentiation datapath.
// Holds the Montgomery multiplier FSM encoding and default width.
package rsa_pkg;

    localparam int RSA_WIDTH = 4;

    typedef enum logic [1:0] {
        MM_IDLE,
        MM_ITER,
        MM_RED
    } mm_state_t;

endpackage

// File: rtl/mm_round.sv
// One radix-2 Montgomery round: conditional add of B and M, then halve.
// Purely combinational so an unrolled multiplier can chain several.
module mm_round #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH+1:0] acc,
    input  logic             a,
    input  logic [WIDTH-1:0] Breg,
    input  logic [WIDTH-1:0] Mreg,
    output logic [WIDTH+1:0] acc_nxt
);

    logic             q;
    logic [WIDTH+1:0] b_ext;
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] sum;

    always_comb begin
        q     = acc[0] ^ (a & Breg[0]);
        b_ext = a ? {2'b00, Breg} : '0;
        m_ext = q ? {2'b00, Mreg} : '0;
        // q makes the sum even, so the shift is an exact divide by 2
        sum     = acc + b_ext + m_ext;
        acc_nxt = sum >> 1;
    end

endmodule

// File: rtl/mont_mult_serial.sv
// Bit-serial Montgomery multiplier: res = A*B*2^-WIDTH mod M.
// One multiplier bit per clock, then a single conditional subtract.
module mont_mult_serial
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] M,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mm_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH+1:0] acc_q;
    logic [WIDTH+1:0] acc_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;

    mm_round #(
        .WIDTH(WIDTH)
    ) u_round (
        .acc    (acc_q),
        .a      (a_q[0]),
        .Breg   (b_q),
        .Mreg   (m_q),
        .acc_nxt(acc_d)
    );

    always_comb begin
        res_d = acc_q[WIDTH-1:0];
        if (acc_q >= {2'b00, m_q}) begin
            res_d = acc_q[WIDTH-1:0] - m_q;
        end
    end

    // a_q shifts right each round so bit 0 is always the current multiplier bit
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= MM_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else if (ena) begin
            unique case (state_q)
                MM_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        m_q     <= M;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MM_ITER;
                    end
                end
                MM_ITER: begin
                    acc_q <= acc_d;
                    a_q   <= a_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= MM_RED;
                    end
                end
                MM_RED: begin
                    res_q   <= res_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= MM_IDLE;
                end
                default: begin
                    state_q <= MM_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;

endmodule

// File: tb/tb_mont_mult_serial.sv
// Self-checking bench for mont_mult_serial at WIDTH=4 and WIDTH=8.
// Expected products come from plain modular arithmetic with a modular inverse.
module tb_mont_mult_serial;

    logic       clk = 1'b0;
    logic       rstb;
    logic       ena4, start4, busy4, done4;
    logic [3:0] A4, B4, M4, res4;
    logic       ena8, start8, busy8, done8;
    logic [7:0] A8, B8, M8, res8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mont_mult_serial #(.WIDTH(4)) dut4 (
        .clk(clk), .rstb(rstb), .ena(ena4), .start(start4),
        .A(A4), .B(B4), .M(M4),
        .busy(busy4), .done(done4), .res(res4)
    );

    mont_mult_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rstb(rstb), .ena(ena8), .start(start8),
        .A(A8), .B(B8), .M(M8),
        .busy(busy8), .done(done8), .res(res8)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int mont_ref(input int a, input int b,
                                    input int m, input int w);
        int r;
        int inv;
        r = (1 << w) % m;
        inv = 0;
        for (int x = 1; x < m; x++) begin
            if (((r * x) % m) == 1) inv = x;
        end
        return (((a * b) % m) * inv) % m;
    endfunction

    task automatic start_op4(input int a, input int b, input int m);
        A4 = 4'(a); B4 = 4'(b); M4 = 4'(m);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
    endtask

    task automatic wait_done4(output int n);
        n = 0;
        while (!done4 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
    endtask

    int n, n2, seen;
    int ta [3] = '{12, 1, 0};
    int tb_ [3] = '{12, 1, 11};
    int ra, rb, rm;

    initial begin
        rstb = 1'b0;
        ena4 = 1'b1; start4 = 1'b0; A4 = '0; B4 = '0; M4 = '0;
        ena8 = 1'b1; start8 = 1'b0; A8 = '0; B8 = '0; M8 = '0;
        tick();
        tick();
        rstb = 1'b1;
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_res", res4, 0);
        chk("rst_res8", res8, 0);

        start_op4(5, 7, 13);
        chk("busy_accept", busy4, 1);
        wait_done4(n);
        chk("lat_basic", n, 5);
        chk("res_basic", res4, mont_ref(5, 7, 13, 4));
        chk("busy_at_done", busy4, 0);
        ena4 = 1'b0;
        tick();
        chk("done_stretch", done4, 1);
        ena4 = 1'b1;
        tick();
        chk("done_pulse", done4, 0);
        chk("res_hold", res4, 3);

        start_op4(12, 12, 13);
        tick();
        tick();
        rstb = 1'b0;
        tick();
        tick();
        chk("midrst_busy", busy4, 0);
        chk("midrst_done", done4, 0);
        chk("midrst_res", res4, 0);
        rstb = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done4) seen++;
        end
        chk("midrst_nodone", seen, 0);

        for (int i = 0; i < 3; i++) begin
            start_op4(ta[i], tb_[i], 13);
            wait_done4(n);
            chk("red_lat", n, 5);
            chk("red_res", res4, mont_ref(ta[i], tb_[i], 13, 4));
            tick();
        end

        A4 = 4'd5; B4 = 4'd7; M4 = 4'd13;
        start4 = 1'b1;
        tick();
        A4 = 4'd1; B4 = 4'd1;
        wait_done4(n);
        chk("b2b_lat", n, 5);
        chk("b2b_res1", res4, 3);
        tick();
        wait_done4(n2);
        start4 = 1'b0;
        chk("b2b_gap", n2 + 1, 6);
        chk("b2b_res2", res4, 9);
        tick();
        chk("b2b_idle", busy4, 0);
        tick();

        start_op4(5, 7, 13);
        tick();
        tick();
        ena4 = 1'b0;
        tick(); tick(); tick();
        chk("ena_busy_hold", busy4, 1);
        ena4 = 1'b1;
        wait_done4(n);
        chk("ena_lat", n + 5, 8);
        chk("ena_res", res4, 3);
        tick();

        start_op4(5, 7, 13);
        A4 = 4'd12; B4 = 4'd12;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4(n);
        chk("ign_lat", n + 1, 5);
        chk("ign_res", res4, 3);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done4) seen++;
        end
        chk("ign_single", seen, 0);

        start_op4(15, 15, 8);
        wait_done4(n);
        chk("even_lat", n, 5);
        tick();

        for (int i = 0; i < 1000; i++) begin
            rm = 2 * $urandom_range(1, 127) + 1;
            ra = $urandom_range(0, rm - 1);
            rb = $urandom_range(0, rm - 1);
            A8 = 8'(ra); B8 = 8'(rb); M8 = 8'(rm);
            start8 = 1'b1;
            tick();
            start8 = 1'b0;
            wait_done8(n);
            chk("rnd_lat", n, 9);
            chk("rnd_res", res8, mont_ref(ra, rb, rm, 8));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
